// File: rtl/brr_pkg.sv
// brr_pkg: bank state type and bit-reverse helper shared by bit_rev_pingpong and brr_bank
package brr_pkg;
  localparam int MAX_AW = 16;
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_state_t;
  function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] v, input int log2n);
    logic [MAX_AW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_AW; i++)
      if (i < log2n) r[i] = v[log2n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/brr_bank.sv
// brr_bank: one ping-pong bank (storage, state FSM, per-frame latched configuration)
module brr_bank import brr_pkg::*; #(
  parameter int DW = 16,
  parameter int AW = 7,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_last,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [LW-1:0] cfg_log2n,
  input  logic          cfg_natural,
  input  logic          promote,
  input  logic          rd_close,
  input  logic [AW-1:0] rd_addr,
  output bank_state_t   state,
  output logic [LW-1:0] log2n,
  output logic          natural,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [2**AW];
  assign rd_data = mem[rd_addr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // a write into a closing DRAINING bank starts the next frame, so it outranks rd_close
  always_ff @(posedge clk)
    if (rst) begin
      state   <= BANK_EMPTY;
      log2n   <= '0;
      natural <= 1'b0;
    end else if (wr_en) begin
      if (state != BANK_FILLING) begin
        log2n   <= cfg_log2n;
        natural <= cfg_natural;
      end
      state <= wr_last ? BANK_FULL : BANK_FILLING;
    end else if (promote) state <= BANK_DRAINING;
    else if (rd_close) state <= BANK_EMPTY;
endmodule

// File: rtl/bit_rev_pingpong.sv
// bit_rev_pingpong: ping-pong frame buffer emitting frames in bit-reversed or natural order.
// Defining BRR_FRAME_CHECK_EN adds in_last and frame_err for frame-boundary checking.
module bit_rev_pingpong import brr_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(ADDR_WIDTH+1)-1:0] cfg_log2n,
  input  logic                          cfg_natural,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
`ifdef BRR_FRAME_CHECK_EN
  input  logic                          in_last,
  output logic                          frame_err,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic                          buffer_full,
  output logic                          buffer_empty
);
  localparam int AW = ADDR_WIDTH;
  localparam int LW = $clog2(ADDR_WIDTH+1);
  localparam logic [AW:0] unit_len = 1;
  bank_state_t st [2];
  logic [LW-1:0] bk_log2n [2];
  logic bk_nat [2];
  logic [DATA_WIDTH-1:0] bk_data [2];
  logic wr_sel, rd_sel, wr_fire, wr_last, issue, rd_last, rd_close;
  logic [AW-1:0] wr_cnt, rd_cnt, rd_addr;
  logic [LW-1:0] cfg_eff, wn, rn;
  logic [AW:0] wlen, rlen;
  assign cfg_eff = (cfg_log2n == '0 || cfg_log2n > LW'(AW)) ? LW'(AW) : cfg_log2n;
  assign rn = bk_log2n[rd_sel];
  assign rlen = unit_len << rn;
  assign rd_last = rd_cnt == AW'(rlen - 1'b1);
  assign issue = st[rd_sel] == BANK_DRAINING && (!out_valid || out_ready);
  assign rd_close = issue && rd_last;
  assign rd_addr = bk_nat[rd_sel] ? rd_cnt : AW'(bitrev(MAX_AW'(rd_cnt), int'(rn)));
  // a bank handing out its final sample this cycle may take the next frame's first sample
  assign in_ready = st[wr_sel] == BANK_EMPTY || st[wr_sel] == BANK_FILLING || (rd_close && rd_sel == wr_sel);
  assign wr_fire = in_valid && in_ready;
  assign wn = st[wr_sel] == BANK_FILLING ? bk_log2n[wr_sel] : cfg_eff;
  assign wlen = unit_len << wn;
  assign wr_last = wr_cnt == AW'(wlen - 1'b1);
  assign buffer_full = !in_ready;
  assign buffer_empty = st[0] == BANK_EMPTY && st[1] == BANK_EMPTY && !out_valid;
  for (genvar g = 0; g < 2; g++) begin : g_bank
    brr_bank #(.DW(DATA_WIDTH), .AW(AW), .LW(LW)) u_bank (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_fire && wr_sel == 1'(g)),
      .wr_last(wr_last),
      .wr_addr(wr_cnt),
      .wr_data(in_data),
      .cfg_log2n(cfg_eff),
      .cfg_natural(cfg_natural),
      .promote(st[g] == BANK_FULL && ((rd_sel == 1'(g)) ^ rd_close)),
      .rd_close(rd_close && rd_sel == 1'(g)),
      .rd_addr(rd_addr),
      .state(st[g]),
      .log2n(bk_log2n[g]),
      .natural(bk_nat[g]),
      .rd_data(bk_data[g])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        wr_sel <= wr_sel ^ wr_last;
      end
      if (issue) begin
        out_data <= bk_data[rd_sel];
        out_last <= rd_last;
        rd_cnt   <= rd_last ? '0 : rd_cnt + 1'b1;
        rd_sel   <= rd_sel ^ rd_last;
      end else if (out_ready) out_last <= 1'b0;
      out_valid <= issue || (out_valid && !out_ready);
    end
`ifdef BRR_FRAME_CHECK_EN
  always_ff @(posedge clk)
    if (rst) frame_err <= 1'b0;
    else frame_err <= wr_fire && (in_last != wr_last);
`endif
endmodule

// File: tb/tb_bit_rev_pingpong.sv
// tb_bit_rev_pingpong: directed, table-driven bench for bit_rev_pingpong
module tb_bit_rev_pingpong;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] cfg_log2n = '0;
  logic cfg_natural = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_last, buffer_full, buffer_empty;
  logic [15:0] out_data;
`ifdef BRR_FRAME_CHECK_EN
  logic in_last = 1'b0;
  logic frame_err;
`endif
  int errors = 0, checks = 0, stalls = 0, gaps = 0;
  logic [15:0] q_data [$];
  logic q_last [$];
  typedef struct {int idx; logic [15:0] data; logic last;} exp_t;
  exp_t tbl [18];

  always #5 clk = ~clk;

  bit_rev_pingpong #(.DATA_WIDTH(16), .ADDR_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .cfg_log2n(cfg_log2n), .cfg_natural(cfg_natural),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef BRR_FRAME_CHECK_EN
    .in_last(in_last), .frame_err(frame_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty)
  );

  always @(negedge clk)
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
    end

  function automatic int brev(input int v, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      r = (r << 1) | (v & 1);
      v = v >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic push(input int d, input int ln, input logic nat, output int t);
    t = 0;
    in_valid = 1'b1;
    in_data = 16'(d);
    cfg_log2n = 3'(ln);
    cfg_natural = nat;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) bound_fail("push_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input int base, input int ln, input logic nat, input int n);
    int t;
    for (int i = 0; i < n; i++) push(base + i, ln, nat, t);
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (q_data.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) bound_fail("wait_out");
  endtask

  initial begin
    int t;
    tbl = '{'{0, 16'd0, 1'b0}, '{1, 16'd4, 1'b0}, '{2, 16'd2, 1'b0}, '{3, 16'd6, 1'b0},
            '{4, 16'd1, 1'b0}, '{5, 16'd5, 1'b0}, '{6, 16'd3, 1'b0}, '{7, 16'd7, 1'b1},
            '{8, 16'd8, 1'b0}, '{9, 16'd9, 1'b0}, '{12, 16'd12, 1'b0}, '{15, 16'd15, 1'b1},
            '{16, 16'd1, 1'b0}, '{17, 16'd65, 1'b0}, '{18, 16'd33, 1'b0}, '{19, 16'd97, 1'b0},
            '{142, 16'd64, 1'b0}, '{143, 16'd128, 1'b1}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_buffer_full", buffer_full, 0);
    chk("rst_buffer_empty", buffer_empty, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // 8-point bit-reversed frame with first-output latency, then natural 8, then 128-point
    for (int i = 0; i < 8; i++) push(i, 3, 1'b0, t);
    chk("lat_e0_valid", out_valid, 0);
    chk("lat_e0_empty", buffer_empty, 0);
    @(posedge clk);
    #1;
    chk("lat_e1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", out_valid, 1);
    chk("lat_e2_data", out_data, 0);
    send(8, 3, 1'b1, 8);
    send(1, 7, 1'b0, 128);
    wait_out(144);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("tbl_data[%0d]", tbl[i].idx), q_data[tbl[i].idx], tbl[i].data);
      chk($sformatf("tbl_last[%0d]", tbl[i].idx), q_last[tbl[i].idx], tbl[i].last);
    end
    for (int j = 0; j < 128; j++)
      chk($sformatf("f7_data[%0d]", j), q_data[16 + j], brev(j, 7) + 1);

    // four back-to-back 128-sample frames; third uses log2n=0 (treated as 7)
    repeat (4) @(posedge clk);
    #1;
    q_data.delete();
    q_last.delete();
    fork
      for (int f = 0; f < 4; f++)
        for (int i = 0; i < 128; i++) begin
          push(3000 + f * 128 + i, f == 2 ? 0 : 7, 1'b0, t);
          stalls += t;
        end
      begin
        int w = 0;
        while (!out_valid && w < 2000) begin
          @(negedge clk);
          w++;
        end
        if (w >= 2000) bound_fail("cont_start");
        for (int i = 0; i < 511; i++) begin
          @(negedge clk);
          if (!out_valid) gaps++;
        end
      end
    join
    chk("cont_in_stalls", stalls, 0);
    chk("cont_out_gaps", gaps, 0);
    wait_out(512);
    for (int k = 0; k < 512; k++) begin
      chk($sformatf("cont_data[%0d]", k), q_data[k], 3000 + (k / 128) * 128 + brev(k % 128, 7));
      chk($sformatf("cont_last[%0d]", k), q_last[k], (k % 128) == 127);
    end

    // back-pressure: second frame fills behind a stalled output
    repeat (4) @(posedge clk);
    #1;
    q_data.delete();
    q_last.delete();
    out_ready = 1'b0;
    send(500, 3, 1'b0, 8);
    send(600, 3, 1'b0, 8);
    @(negedge clk);
    chk("bp_buffer_full", buffer_full, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 500);
    repeat (3) @(negedge clk);
    chk("bp_hold_data", out_data, 500);
    chk("bp_hold_last", out_last, 0);
    out_ready = 1'b1;
    wait_out(16);
    repeat (5) @(negedge clk);
    chk("bp_count", q_data.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("bp_data[%0d]", k), q_data[k], (k < 8 ? 500 : 600) + brev(k % 8, 3));
      chk($sformatf("bp_last[%0d]", k), q_last[k], (k % 8) == 7);
    end

    // reset mid-frame discards the held frame and the partial one
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(100, 3, 1'b0, 8);
    send(1000, 7, 1'b0, 50);
    chk("mid_pre_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_out_last", out_last, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_buffer_full", buffer_full, 0);
    chk("mid_buffer_empty", buffer_empty, 1);
    q_data.delete();
    q_last.delete();
    out_ready = 1'b1;
    send(2000, 7, 1'b1, 128);
    wait_out(128);
    repeat (10) @(negedge clk);
    chk("post_rst_count", q_data.size(), 128);
    for (int j = 0; j < 128; j++) begin
      chk($sformatf("post_rst_data[%0d]", j), q_data[j], 2000 + j);
      chk($sformatf("post_rst_last[%0d]", j), q_last[j], j == 127);
    end

`ifdef BRR_FRAME_CHECK_EN
    // early in_last flags an error but the frame still closes by count
    @(posedge clk);
    #1;
    q_data.delete();
    q_last.delete();
    for (int k = 0; k < 8; k++) begin
      in_last = (k == 5);
      push(k, 3, 1'b0, t);
      if (k == 5) chk("ferr_pulse", frame_err, 1);
      if (k == 6) chk("ferr_clear", frame_err, 0);
    end
    in_last = 1'b0;
    wait_out(8);
    chk("ferr_close_last", q_last[7], 1);
    chk("ferr_close_data", q_data[7], 7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
